// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: forward-mux encodings,
// the in-flight destination record carried down EX/MEM/WB, and FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic       vld;
    logic       we;
    logic       is_load;
    logic [4:0] rd;
  } inflight_t;

  typedef enum logic {RUN, STALL} hz_state_t;

  // A slot only produces a value when it is real, writes, and is not x0.
  function automatic logic is_producer(input inflight_t s);
    return s.vld & s.we & (s.rd != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Forward-mux select for one EX operand. MEM (youngest) beats WB; a load
// sitting in MEM has no data yet, so it is skipped and the stall guarantees
// the consumer meets it in WB instead.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] ex_rs,
  input  inflight_t        mem_slot,
  input  inflight_t        wb_slot,
  output logic [1:0]       sel
);

  logic [4:0] rs;
  assign rs = 5'(ex_rs);

  // Priority select: MEM non-load, then WB, else register file.
  always_comb begin
    sel = FWD_RF;
    if (is_producer(mem_slot) && !mem_slot.is_load && (mem_slot.rd == rs))
      sel = FWD_MEM;
    else if (is_producer(wb_slot) && (wb_slot.rd == rs))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller for the 5-stage core. Tracks in-flight
// destinations in EX/MEM/WB, drives the EX operand forward muxes, and holds
// the front end behind loads for LOAD_STALL cycles.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal issue; a load-use hazard stalls combinationally
// STALL | extra load-use stall cycles, cnt counts down to 1 then RUN
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic             flush,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel
);

  inflight_t        ex_q, mem_q, wb_q;
  hz_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             haz;
  logic [4:0]       rs1, rs2;

  assign rs1 = 5'(id_rs1);
  assign rs2 = 5'(id_rs2);

  // Load-use hazard against the load currently in EX.
  always_comb begin
    haz = (state == RUN) && id_valid && is_producer(ex_q) && ex_q.is_load &&
          (((ex_q.rd == rs1) && id_use_rs1) || ((ex_q.rd == rs2) && id_use_rs2));
  end

  // Flush overrides any stall but still squashes the ID/EX entry.
  always_comb begin
    stall_if_id = !flush && (haz || (state == STALL));
    bubble_ex   = flush || stall_if_id;
  end

  // Slot pipeline: EX takes the ID instruction or a bubble; MEM/WB always drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bubble_ex)
        ex_q <= '0;
      else
        ex_q <= '{vld: id_valid, we: id_rd_we, is_load: id_is_load, rd: 5'(id_rd)};
    end
  end

  // Stall FSM with a down-counter; terminal count 1 returns to RUN.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (haz && (LOAD_STALL > 1)) begin
            state <= STALL;
            cnt   <= CNT_W'(LOAD_STALL - 1);
          end
        end
        STALL: begin
          if (cnt == CNT_W'(1)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .ex_rs    (ex_rs1),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (fwd_a_sel)
  );

  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .ex_rs    (ex_rs2),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (fwd_b_sel)
  );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: one instance with LOAD_STALL=1
// walks a cycle-by-cycle vector table, a second with LOAD_STALL=3 covers the
// multi-cycle stall, flush and reset-mid-stall sequences.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs1, id_use_rs2, id_rd_we, id_is_load, flush;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2;

  logic       st1, bu1, st3, bu3;
  logic [1:0] a1, b1, a3, b3;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       we, ld;
    logic [4:0] e1, e2;
    logic       fl;
    logic       st, bu;
    logic [1:0] a, b;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_W(5), .LOAD_STALL(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .flush(flush), .stall_if_id(st1), .bubble_ex(bu1), .fwd_a_sel(a1), .fwd_b_sel(b1)
  );

  hazard_forward_unit #(.REG_W(5), .LOAD_STALL(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .flush(flush), .stall_if_id(st3), .bubble_ex(bu3), .fwd_a_sel(a3), .fwd_b_sel(b3)
  );

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic we, input logic ld, input logic [4:0] e1,
                              input logic [4:0] e2, input logic fl, input logic st,
                              input logic bu, input logic [1:0] a, input logic [1:0] b);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd;
    t.we = we; t.ld = ld; t.e1 = e1; t.e2 = e2; t.fl = fl;
    t.st = st; t.bu = bu; t.a = a; t.b = b;
    return t;
  endfunction

  // Drive one cycle of inputs after the falling edge; outputs settle by +2.
  task automatic apply(input vec_t t, input logic r);
    @(negedge clk);
    rst = r;
    id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2; id_use_rs1 = t.u1; id_use_rs2 = t.u2;
    id_rd = t.rd; id_rd_we = t.we; id_is_load = t.ld;
    ex_rs1 = t.e1; ex_rs2 = t.e2; flush = t.fl;
    #2;
  endtask

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got {stall,bubble,a,b}=%b_%b_%b_%b expected %b_%b_%b_%b",
               name, got[5], got[4], got[3:2], got[1:0], exp[5], exp[4], exp[3:2], exp[1:0]);
    end
  endtask

  vec_t idle, ld7, use7, ld7b;

  initial begin
    // cycle table for LOAD_STALL=1: v rs1 rs2 u1 u2 rd we ld | ex1 ex2 fl | st bu a b
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0,  0, 0,0, 0,0,2'd0,2'd0)); // reset state
    tbl.push_back(mk(1, 1, 2, 1,1,  5,1'b1,0,  0, 0,0, 0,0,2'd0,2'd0)); // add x5
    tbl.push_back(mk(1, 5, 3, 1,1,  8,1'b1,0,  1, 2,0, 0,0,2'd0,2'd0)); // sub x8,x5,x3
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0,  5, 3,0, 0,0,2'd1,2'd0)); // sub in EX: x5 from MEM
    tbl.push_back(mk(1, 0, 0, 1,0,  6,1'b1,0,  8, 5,0, 0,0,2'd1,2'd2)); // x8 MEM, x5 WB
    tbl.push_back(mk(1, 1, 2, 1,1,  5,1'b1,0,  0, 0,0, 0,0,2'd0,2'd0)); // add x5
    tbl.push_back(mk(1, 0, 0, 1,0,  6,1'b1,0,  6, 0,0, 0,0,2'd1,2'd0)); // addi x6
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0,  5, 6,0, 0,0,2'd1,2'd2));
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0,  5, 6,0, 0,0,2'd2,2'd1)); // x5 WB, x6 MEM
    tbl.push_back(mk(1, 1, 2, 1,1,  7,1'b1,0,  0, 0,0, 0,0,2'd0,2'd0)); // add x7 (a)
    tbl.push_back(mk(1, 1, 2, 1,1,  7,1'b1,0,  0, 0,0, 0,0,2'd0,2'd0)); // add x7 (b)
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0,  0, 0,0, 0,0,2'd0,2'd0));
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0,  7, 7,0, 0,0,2'd1,2'd1)); // MEM beats WB
    tbl.push_back(mk(1, 1, 2, 1,1, 10,1'b0,0,  0, 0,0, 0,0,2'd0,2'd0)); // store, rd=10 we=0
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0, 10, 0,0, 0,0,2'd0,2'd0));
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0, 10,10,0, 0,0,2'd0,2'd0)); // we=0 never forwards
    tbl.push_back(mk(1, 2, 0, 1,0,  7,1'b1,1,  0, 0,0, 0,0,2'd0,2'd0)); // lw x7
    tbl.push_back(mk(1, 1, 7, 1,1,  9,1'b1,0,  2, 0,0, 1,1,2'd0,2'd0)); // use rs2=x7: stall
    tbl.push_back(mk(1, 1, 7, 1,1,  9,1'b1,0,  0, 0,0, 0,0,2'd0,2'd0)); // single stall only
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0,  1, 7,0, 0,0,2'd0,2'd2)); // x7 from WB
    tbl.push_back(mk(1, 3, 0, 1,0, 11,1'b1,1,  0, 0,0, 0,0,2'd0,2'd0)); // lw x11
    tbl.push_back(mk(1, 1, 2, 1,1, 12,1'b1,0,  3, 0,0, 0,0,2'd0,2'd0)); // independent
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0, 11,11,0, 0,0,2'd0,2'd0)); // load in MEM: no fwd
    tbl.push_back(mk(1, 4, 0, 1,0, 13,1'b1,1,  0, 0,0, 0,0,2'd0,2'd0)); // lw x13
    tbl.push_back(mk(1,13,13, 0,0,  0,1'b0,0,  0, 0,0, 0,0,2'd0,2'd0)); // match, not used
    tbl.push_back(mk(1, 4, 0, 1,0, 14,1'b1,1,  0, 0,0, 0,0,2'd0,2'd0)); // lw x14
    tbl.push_back(mk(0,14, 0, 1,0,  0,1'b0,0,  0, 0,0, 0,0,2'd0,2'd0)); // match, ID invalid
    tbl.push_back(mk(1, 4, 0, 1,0, 15,1'b1,1,  0, 0,0, 0,0,2'd0,2'd0)); // lw x15
    tbl.push_back(mk(1,15, 0, 1,0, 16,1'b1,0,  0, 0,0, 1,1,2'd0,2'd0)); // use rs1=x15: stall
    tbl.push_back(mk(1,15, 0, 1,0, 16,1'b1,0,  0, 0,0, 0,0,2'd0,2'd0));
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0, 15, 0,0, 0,0,2'd2,2'd0)); // x15 from WB
    tbl.push_back(mk(1, 4, 0, 1,0,  0,1'b1,1,  0, 0,0, 0,0,2'd0,2'd0)); // lw x0
    tbl.push_back(mk(1, 0, 0, 1,1, 17,1'b1,0,  0, 0,0, 0,0,2'd0,2'd0)); // use x0: no stall
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0,  0, 0,0, 0,0,2'd0,2'd0));
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0,  0, 0,0, 0,0,2'd0,2'd0)); // lw x0 in WB
    tbl.push_back(mk(1, 1, 2, 1,1,  0,1'b1,0,  0, 0,0, 0,0,2'd0,2'd0)); // add x0
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0,  0, 0,0, 0,0,2'd0,2'd0));
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0,  0, 0,0, 0,0,2'd0,2'd0)); // add x0 in MEM
    tbl.push_back(mk(1, 4, 0, 1,0, 15,1'b1,1,  0, 0,0, 0,0,2'd0,2'd0)); // lw x15
    tbl.push_back(mk(1,15, 0, 1,0, 16,1'b1,0,  0, 0,1, 0,1,2'd0,2'd0)); // haz + flush
    tbl.push_back(mk(1,15, 0, 1,0, 16,1'b1,0,  0, 0,0, 0,0,2'd0,2'd0)); // no stall recorded
    tbl.push_back(mk(0, 0, 0, 0,0,  0,1'b0,0,  0, 0,1, 0,1,2'd0,2'd0)); // flush alone
    tbl.push_back(mk(1, 4, 0, 1,0, 18,1'b1,1,  0, 0,1, 0,1,2'd0,2'd0)); // flushed lw x18
    tbl.push_back(mk(1, 0,18, 0,1, 19,1'b1,0,  0, 0,0, 0,0,2'd0,2'd0)); // squashed: no stall

    idle = mk(0, 0, 0, 0,0, 0,1'b0,0, 0,0,0, 0,0,2'd0,2'd0);
    ld7  = mk(1, 2, 0, 1,0, 7,1'b1,1, 0,0,0, 0,0,2'd0,2'd0);
    use7 = mk(1, 1, 7, 1,1, 9,1'b1,0, 0,0,0, 0,0,2'd0,2'd0);

    // initial reset cycle, unchecked (state is unknown before it)
    apply(idle, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], 1'b0);
      check($sformatf("ls1_row%0d", i), {st1, bu1, a1, b1},
            {tbl[i].st, tbl[i].bu, tbl[i].a, tbl[i].b});
    end

    // LOAD_STALL=3: three stall cycles, then back to RUN with no re-stall
    apply(idle, 1'b1);
    apply(ld7, 1'b0);
    check("ls3_load_issue", {st3, bu3, a3, b3}, 6'b00_00_00);
    apply(use7, 1'b0);
    check("ls3_stall_c0", {st3, bu3, a3, b3}, 6'b11_00_00);
    check("ls1_stall_c0", {st1, bu1, a1, b1}, 6'b11_00_00);
    apply(use7, 1'b0);
    check("ls3_stall_c1", {st3, bu3, a3, b3}, 6'b11_00_00);
    check("ls1_released", {st1, bu1, a1, b1}, 6'b00_00_00);
    apply(use7, 1'b0);
    check("ls3_stall_c2", {st3, bu3, a3, b3}, 6'b11_00_00);
    apply(use7, 1'b0);
    check("ls3_released", {st3, bu3, a3, b3}, 6'b00_00_00);
    apply(idle, 1'b0);
    check("ls3_no_restall", {st3, bu3, a3, b3}, 6'b00_00_00);

    // LOAD_STALL=3: flush during the hazard cycle records no stall
    apply(ld7, 1'b0);
    ld7b = use7;
    ld7b.fl = 1'b1;
    apply(ld7b, 1'b0);
    check("ls3_haz_flush", {st3, bu3, a3, b3}, 6'b01_00_00);
    apply(use7, 1'b0);
    check("ls3_after_flush", {st3, bu3, a3, b3}, 6'b00_00_00);

    // LOAD_STALL=3: reset in the middle of a stall
    apply(ld7, 1'b0);
    apply(use7, 1'b0);
    check("ls3_pre_rst_stall", {st3, bu3, a3, b3}, 6'b11_00_00);
    apply(use7, 1'b0);
    check("ls3_pre_rst_stall2", {st3, bu3, a3, b3}, 6'b11_00_00);
    apply(use7, 1'b1);
    ld7b = use7;
    ld7b.e1 = 5'd7;
    ld7b.e2 = 5'd7;
    apply(ld7b, 1'b0);
    check("ls3_post_rst", {st3, bu3, a3, b3}, 6'b00_00_00);
    check("ls1_post_rst", {st1, bu1, a1, b1}, 6'b00_00_00);
    apply(ld7b, 1'b0);
    check("ls3_post_rst_run", {st3, bu3, a3, b3}, 6'b00_00_00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
